// File: rtl/cpu_pkg.sv
// Shared CPU definitions: forwarding select codes, in-flight result record,
// MDU latency defaults and the saturating Tnew decrement.
package cpu_pkg;

    localparam int TW                = 4;
    localparam int MULT_CYCLES_DEF   = 5;
    localparam int DIV_CYCLES_DEF    = 10;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_E  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;
    localparam logic [1:0] FWD_W  = 2'b11;

    // One in-flight result: destination register and cycles until it exists.
    typedef struct packed {
        logic [4:0]    a3;
        logic [TW-1:0] tnew;
    } stage_rec_t;

    // Tnew counts down as the result moves one stage further, never below 0.
    function automatic logic [TW-1:0] satDec(input logic [TW-1:0] x);
        return (x != '0) ? x - 1'b1 : '0;
    endfunction

endpackage

// File: rtl/hazard_scheduler_if.sv
// D-stage hazard query bus between the decode stage (master) and the hazard
// scheduler (slave). The optional stall_cnt wire exists only when
// HAZARD_STATS_EN is defined.
//
// Handshake: there is no valid/ready pair; the D fields are sampled every cycle
// and stall is the only back-pressure. While stall=1 the master must hold its
// D fields, and the scheduler pushes a bubble into E instead of the D instruction.
interface hazard_scheduler_if #(
    parameter int TW = cpu_pkg::TW
);
    logic [4:0]    rs_d;
    logic [4:0]    rt_d;
    logic [TW-1:0] tuse_rs_d;
    logic [TW-1:0] tuse_rt_d;
    logic [4:0]    a3_d;
    logic [TW-1:0] tnew_d;
    logic          md_start_d;
    logic          md_div_d;
    logic          md_use_d;
    logic          stall;
    logic [1:0]    fwd_rs;
    logic [1:0]    fwd_rt;
    logic          md_busy;
`ifdef HAZARD_STATS_EN
    logic [31:0]   stall_cnt;
`endif

    modport master (
        output rs_d, rt_d, tuse_rs_d, tuse_rt_d, a3_d, tnew_d,
               md_start_d, md_div_d, md_use_d,
        input  stall, fwd_rs, fwd_rt, md_busy
`ifdef HAZARD_STATS_EN
        , input stall_cnt
`endif
    );

    modport slave (
        input  rs_d, rt_d, tuse_rs_d, tuse_rt_d, a3_d, tnew_d,
               md_start_d, md_div_d, md_use_d,
        output stall, fwd_rs, fwd_rt, md_busy
`ifdef HAZARD_STATS_EN
        , output stall_cnt
`endif
    );

endinterface

// File: rtl/md_busy_timer.sv
// Multiply/divide unit busy window. A start that reaches E raises busy for that
// cycle, then the counter keeps it raised for the unit's latency.
module md_busy_timer #(
    parameter int MULT_CYCLES = cpu_pkg::MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = cpu_pkg::DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic startIn,   // MDU start actually entering E this edge
    input  logic divIn,     // that start is a divide
    output logic mdBusy
);

    localparam int MAXC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    logic          startE;
    logic          divE;
    logic [CW-1:0] cnt;

    // Track the start in E and load/count down the remaining busy cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            startE <= 1'b0;
            divE   <= 1'b0;
            cnt    <= '0;
        end else begin
            startE <= startIn;
            divE   <= divIn;
            if (startE) begin
                cnt <= divE ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign mdBusy = startE | (cnt != '0);

endmodule

// File: rtl/hazard_scheduler.sv
// Pipeline hazard controller: tracks in-flight results through E/M/W, raises the
// D stall (data and MDU), selects operand forwarding and runs the MDU busy timer.
// Optional feature macro: HAZARD_STATS_EN adds a saturating stall cycle counter.
module hazard_scheduler
    import cpu_pkg::*;
#(
    parameter int MULT_CYCLES = cpu_pkg::MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = cpu_pkg::DIV_CYCLES_DEF
) (
    input logic               clk,
    input logic               reset_n,
    hazard_scheduler_if.slave hs
);

    stage_rec_t stageE;
    stage_rec_t stageM;
    stage_rec_t stageW;
    logic       dataStall;
    logic       mdBusy;
    logic       stall;
    logic [1:0] fwdRs;
    logic [1:0] fwdRt;

    // A source waits if E or M will not have its value by the time D needs it.
    function automatic logic srcStall(input logic [4:0] src, input logic [TW-1:0] tuse,
                                      input stage_rec_t e, input stage_rec_t m);
        logic hit;
        hit = 1'b0;
        if (src != 5'd0) begin
            if (e.a3 == src && e.tnew > tuse) hit = 1'b1;
            if (m.a3 == src && m.tnew > tuse) hit = 1'b1;
        end
        return hit;
    endfunction

    // Youngest matching record wins; it forwards only once its value exists.
    function automatic logic [1:0] srcFwd(input logic [4:0] src, input stage_rec_t e,
                                          input stage_rec_t m, input stage_rec_t w);
        logic [1:0] sel;
        sel = FWD_RF;
        if (src != 5'd0) begin
            if (e.a3 == src)      sel = (e.tnew == '0) ? FWD_E : FWD_RF;
            else if (m.a3 == src) sel = (m.tnew == '0) ? FWD_M : FWD_RF;
            else if (w.a3 == src) sel = (w.tnew == '0) ? FWD_W : FWD_RF;
        end
        return sel;
    endfunction

    // Zero-latency stall and forwarding decisions from records and D fields.
    always_comb begin
        dataStall = srcStall(hs.rs_d, hs.tuse_rs_d, stageE, stageM)
                  | srcStall(hs.rt_d, hs.tuse_rt_d, stageE, stageM);
        stall     = dataStall | (hs.md_use_d & mdBusy);
        fwdRs     = srcFwd(hs.rs_d, stageE, stageM, stageW);
        fwdRt     = srcFwd(hs.rt_d, stageE, stageM, stageW);
    end

    // Advance the in-flight records every cycle; a stall only swaps D for a bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stageE <= '0;
            stageM <= '0;
            stageW <= '0;
        end else begin
            stageW <= '{a3: stageM.a3, tnew: satDec(stageM.tnew)};
            stageM <= '{a3: stageE.a3, tnew: satDec(stageE.tnew)};
            stageE <= stall ? '0 : '{a3: hs.a3_d, tnew: hs.tnew_d};
        end
    end

    md_busy_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_mdTimer (
        .clk     (clk),
        .reset_n (reset_n),
        .startIn (hs.md_start_d & ~stall),
        .divIn   (hs.md_div_d & ~stall),
        .mdBusy  (mdBusy)
    );

    assign hs.stall   = stall;
    assign hs.fwd_rs  = fwdRs;
    assign hs.fwd_rt  = fwdRt;
    assign hs.md_busy = mdBusy;

`ifdef HAZARD_STATS_EN
    logic [31:0] stallCnt;

    // Count stalled cycles, holding at the maximum instead of wrapping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stallCnt <= '0;
        end else if (stall && stallCnt != 32'hFFFF_FFFF) begin
            stallCnt <= stallCnt + 32'd1;
        end
    end

    assign hs.stall_cnt = stallCnt;
`endif

endmodule

// File: tb/tb_hazard_scheduler.sv
// Bench for hazard_scheduler: directed pipeline scenarios with literal
// expectations, then randomized D-stage traffic checked every cycle against a
// timeline model (absolute ready cycles per issued result).
module tb_hazard_scheduler;

    localparam int MULTC = 5;
    localparam int DIVC  = 10;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    bit   checkEn = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    hazard_scheduler_if #(.TW(4)) hs ();

    hazard_scheduler #(.MULT_CYCLES(MULTC), .DIV_CYCLES(DIVC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .hs      (hs)
    );

    // ---------------- reference model ----------------
    // Each issued slot remembers its destination and the absolute cycle at
    // which its result exists. hist[0] is the newest slot (in E), hist[1] M, hist[2] W.
    typedef struct {
        int a3;
        int ready;
    } ent_t;

    ent_t hist[$];
    int   cyc         = 0;
    int   mdBusyEnd   = -1;
    int   expStallCnt = 0;
    int   sA3, sTnew;
    bit   sStall, sStart, sDiv;

    function automatic void modelClear();
        hist.delete();
        for (int i = 0; i < 3; i++) hist.push_back('{0, 0});
        mdBusyEnd   = -1;
        expStallCnt = 0;
        sStall = 0; sStart = 0; sDiv = 0; sA3 = 0; sTnew = 0;
    endfunction

    function automatic int remaining(int i);
        return (hist[i].ready > cyc) ? hist[i].ready - cyc : 0;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    // Compare process: expected outputs for the current cycle.
    always @(negedge clk) begin : compare
        int  srcs [2];
        int  tuses[2];
        int  fwdX [2];
        bit  found;
        bit  eStall;
        bit  eBusy;
        if (checkEn) begin
            srcs[0]  = int'(hs.rs_d);      srcs[1]  = int'(hs.rt_d);
            tuses[0] = int'(hs.tuse_rs_d); tuses[1] = int'(hs.tuse_rt_d);
            eStall = 0;
            for (int s = 0; s < 2; s++) begin
                fwdX[s] = 0;
                if (srcs[s] != 0) begin
                    for (int i = 0; i < 2; i++)
                        if (hist[i].a3 == srcs[s] && remaining(i) > tuses[s]) eStall = 1;
                    found = 0;
                    for (int i = 0; i < 3; i++) begin
                        if (!found && hist[i].a3 == srcs[s]) begin
                            found = 1;
                            if (remaining(i) == 0) fwdX[s] = i + 1;
                        end
                    end
                end
            end
            eBusy = (cyc <= mdBusyEnd);
            if (hs.md_use_d && eBusy) eStall = 1;
            chk("stall",   int'(hs.stall),   int'(eStall));
            chk("fwd_rs",  int'(hs.fwd_rs),  fwdX[0]);
            chk("fwd_rt",  int'(hs.fwd_rt),  fwdX[1]);
            chk("md_busy", int'(hs.md_busy), int'(eBusy));
`ifdef HAZARD_STATS_EN
            chk("stall_cnt", int'(hs.stall_cnt), expStallCnt);
`endif
            sStall = eStall;
            sA3    = int'(hs.a3_d);
            sTnew  = int'(hs.tnew_d);
            sStart = hs.md_start_d;
            sDiv   = hs.md_div_d;
        end
    end

    // Model timeline step at each active edge.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            modelClear();
        end else if (checkEn) begin
            cyc++;
            hist.push_front('{sStall ? 0 : sA3, cyc + sTnew});
            void'(hist.pop_back());
            if (sStart && !sStall) mdBusyEnd = cyc + (sDiv ? DIVC : MULTC);
            if (sStall) expStallCnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic setD(input int rs, input int rt, input int tuRs, input int tuRt,
                        input int a3, input int tnew, input bit st, input bit dv, input bit us);
        hs.rs_d       = 5'(rs);
        hs.rt_d       = 5'(rt);
        hs.tuse_rs_d  = 4'(tuRs);
        hs.tuse_rt_d  = 4'(tuRt);
        hs.a3_d       = 5'(a3);
        hs.tnew_d     = 4'(tnew);
        hs.md_start_d = st;
        hs.md_div_d   = dv;
        hs.md_use_d   = us;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        modelClear();
        setD(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        checkEn = 1'b1;

        // reset state with live source registers
        setD(7, 9, 0, 0, 0, 0, 0, 0, 1);
        #2;
        chk("rst_stall", int'(hs.stall), 0);
        chk("rst_fwd_rs", int'(hs.fwd_rs), 0);
        chk("rst_busy", int'(hs.md_busy), 0);
        tick();

        // lw $1 (Tnew 2) then addu using $1 with Tuse 1: one stall cycle
        setD(0, 0, 0, 0, 1, 2, 0, 0, 0);
        #2 chk("lw_issue_stall", int'(hs.stall), 0);
        tick();
        setD(1, 0, 1, 3, 4, 1, 0, 0, 0);
        #2 chk("lw_use_stall", int'(hs.stall), 1);
        tick();
        #2 chk("lw_use_release", int'(hs.stall), 0);
        tick();

        // addu $2 (Tnew 1) then beq on $2 (Tuse 0): stall then forward from M
        setD(0, 0, 0, 0, 2, 1, 0, 0, 0);
        tick();
        setD(2, 0, 0, 3, 0, 0, 0, 0, 0);
        #2 chk("beq_stall", int'(hs.stall), 1);
        tick();
        #2 chk("beq_release", int'(hs.stall), 0);
        chk("beq_fwd_m", int'(hs.fwd_rs), 2);
        tick();

        // addu $3, nop, sw using $3 (Tuse 2): no stall, forward from M
        setD(0, 0, 0, 0, 3, 1, 0, 0, 0);
        tick();
        setD(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        setD(0, 3, 3, 2, 0, 0, 0, 0, 0);
        #2 chk("sw_stall", int'(hs.stall), 0);
        chk("sw_fwd_rt", int'(hs.fwd_rt), 2);
        tick();

        // writes to $0 flowing through E, M, W with unused sources
        for (int i = 0; i < 4; i++) begin
            setD(0, 0, 0, 0, 0, 3, 0, 0, 0);
            #2;
            chk("r0_stall", int'(hs.stall), 0);
            chk("r0_fwd", int'({hs.fwd_rs, hs.fwd_rt}), 0);
            tick();
        end

        // div then mflo (11 busy cycles), then mult then mflo (6 busy cycles)
        for (int v = 0; v < 2; v++) begin
            int n;
            n = (v == 0) ? DIVC + 1 : MULTC + 1;
            setD(0, 0, 0, 0, 0, 0, 1, (v == 0), 1);
            tick();
            setD(0, 0, 0, 0, 0, 0, 0, 0, 1);
            for (int i = 0; i < n; i++) begin
                #2;
                chk("md_hold_stall", int'(hs.stall), 1);
                chk("md_hold_busy", int'(hs.md_busy), 1);
                tick();
            end
            #2;
            chk("md_done_stall", int'(hs.stall), 0);
            chk("md_done_busy", int'(hs.md_busy), 0);
            tick();
        end

        // async reset mid-divide with E holding {5, 2}
        setD(0, 0, 0, 0, 5, 2, 1, 1, 1);
        tick();
        setD(5, 0, 0, 0, 0, 0, 0, 0, 1);
        #2;
        chk("pre_rst_stall", int'(hs.stall), 1);
        chk("pre_rst_busy", int'(hs.md_busy), 1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_stall", int'(hs.stall), 0);
        chk("async_rst_fwd", int'(hs.fwd_rs), 0);
        chk("async_rst_busy", int'(hs.md_busy), 0);
`ifdef HAZARD_STATS_EN
        chk("async_rst_cnt", int'(hs.stall_cnt), 0);
`endif
        #3 reset_n = 1'b1;
        tick();

        // randomized traffic, with one asynchronous reset in the middle
        for (int i = 0; i < 3000; i++) begin
            bit st;
            st = ($urandom_range(0, 15) == 0);
            setD($urandom_range(0, 4), $urandom_range(0, 4),
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 4), $urandom_range(0, 3),
                 st, $urandom_range(0, 1), st | ($urandom_range(0, 7) == 0));
            if (i == 1500) begin
                #2 reset_n = 1'b0;
                #1;
                chk("rand_rst_stall", int'(hs.stall), 0);
                chk("rand_rst_busy", int'(hs.md_busy), 0);
                #3 reset_n = 1'b1;
            end
            tick();
        end

        checkEn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
